// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: boot delay, trap > EX > ID redirect arbitration, pending redirect across fetch stalls.
// Zero latency (all outputs combinational); while stall_if is high the PC is frozen and a redirect is held pending.
module pc_sequencer #(
  parameter int BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_if,
  input  logic        trap_req,
  input  logic [31:0] trap_vector,
  input  logic        ex_redirect_req,
  input  logic [31:0] ex_target,
  input  logic        id_jump_req,
  input  logic [31:0] id_target,
  output logic        pc_enable,
  output logic        pc_load_enable,
  output logic [31:0] pc_load,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        redirect_taken,
  output logic [1:0]  redirect_src,
  output logic        misaligned_target
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_ID   = 2'd1;
  localparam logic [1:0] SRC_EX   = 2'd2;
  localparam logic [1:0] SRC_TRAP = 2'd3;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [1:0]  pend_src_q, pend_src_d;

  logic [1:0]  arb_src;
  logic [31:0] arb_target;
  logic        arb_misaligned;
  logic        arb_vld;
  logic        hold_override;
  logic [2:0]  flush_vec;

  // Flush depth grows with the age of the redirecting stage: {ex_mem, id_ex, if_id}.
  function automatic logic [2:0] flush_for(input logic [1:0] src);
    logic [2:0] f;
    case (src)
      SRC_TRAP: f = 3'b111;
      SRC_EX:   f = 3'b011;
      SRC_ID:   f = 3'b001;
      default:  f = 3'b000;
    endcase
    return f;
  endfunction

  // A misaligned EX/ID target is turned into a trap so the PC never holds a bad fetch address.
  always_comb begin
    arb_src        = SRC_NONE;
    arb_target     = 32'd0;
    arb_misaligned = 1'b0;
    if (trap_req) begin
      arb_src    = SRC_TRAP;
      arb_target = trap_vector;
    end else if (ex_redirect_req) begin
      if (ex_target[1:0] != 2'b00) begin
        arb_src        = SRC_TRAP;
        arb_target     = trap_vector;
        arb_misaligned = 1'b1;
      end else begin
        arb_src    = SRC_EX;
        arb_target = ex_target;
      end
    end else if (id_jump_req) begin
      if (id_target[1:0] != 2'b00) begin
        arb_src        = SRC_TRAP;
        arb_target     = trap_vector;
        arb_misaligned = 1'b1;
      end else begin
        arb_src    = SRC_ID;
        arb_target = id_target;
      end
    end
  end

  assign arb_vld       = (arb_src != SRC_NONE);
  assign hold_override = arb_vld && (arb_src >= pend_src_q);

  always_comb begin
    state_d        = state_q;
    boot_cnt_d     = boot_cnt_q;
    pend_vld_d     = pend_vld_q;
    pend_target_d  = pend_target_q;
    pend_src_d     = pend_src_q;

    pc_enable         = 1'b0;
    pc_load_enable    = 1'b0;
    pc_load           = 32'd0;
    flush_vec         = 3'b000;
    redirect_taken    = 1'b0;
    redirect_src      = SRC_NONE;
    misaligned_target = 1'b0;

    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q >= BOOT_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (arb_vld) begin
          flush_vec         = flush_for(arb_src);
          redirect_src      = arb_src;
          misaligned_target = arb_misaligned;
          if (stall_if) begin
            pend_vld_d    = 1'b1;
            pend_target_d = arb_target;
            pend_src_d    = arb_src;
            state_d       = ST_HOLD;
          end else begin
            pc_enable      = 1'b1;
            pc_load_enable = 1'b1;
            pc_load        = arb_target;
            redirect_taken = 1'b1;
          end
        end else begin
          pc_enable = !stall_if;
        end
      end

      ST_HOLD: begin
        // Flushes only fire when a fresh request wins; the pending entry already flushed at capture.
        if (hold_override) begin
          flush_vec         = flush_for(arb_src);
          misaligned_target = arb_misaligned;
          redirect_src      = arb_src;
        end else begin
          redirect_src = pend_src_q;
        end
        if (stall_if) begin
          if (hold_override) begin
            pend_target_d = arb_target;
            pend_src_d    = arb_src;
          end
        end else begin
          pc_enable      = 1'b1;
          pc_load_enable = 1'b1;
          pc_load        = hold_override ? arb_target : pend_target_q;
          redirect_taken = 1'b1;
          pend_vld_d     = 1'b0;
          pend_target_d  = 32'd0;
          pend_src_d     = SRC_NONE;
          state_d        = ST_RUN;
        end
      end

      default: begin
        state_d    = ST_BOOT;
        boot_cnt_d = 4'd0;
        pend_vld_d = 1'b0;
      end
    endcase
  end

  assign flush_if_id  = flush_vec[0];
  assign flush_id_ex  = flush_vec[1];
  assign flush_ex_mem = flush_vec[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      boot_cnt_q    <= 4'd0;
      pend_vld_q    <= 1'b0;
      pend_target_q <= 32'd0;
      pend_src_q    <= SRC_NONE;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      pend_vld_q    <= pend_vld_d;
      pend_target_q <= pend_target_d;
      pend_src_q    <= pend_src_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, every cycle compared with a priority-number model.
module tb_pc_sequencer;
  localparam int BOOT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_if = 1'b0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_vector = 32'd0;
  logic        ex_redirect_req = 1'b0;
  logic [31:0] ex_target = 32'd0;
  logic        id_jump_req = 1'b0;
  logic [31:0] id_target = 32'd0;
  logic        pc_enable, pc_load_enable, flush_if_id, flush_id_ex, flush_ex_mem;
  logic        redirect_taken, misaligned_target;
  logic [31:0] pc_load;
  logic [1:0]  redirect_src;

  int errors = 0;
  int checks = 0;

  // Model: frozen cycles left, plus an optional pending redirect as (priority, address).
  int          boot_left;
  bit          pend;
  int          pend_prio;
  logic [31:0] pend_addr;

  pc_sequencer #(.BOOT_CYCLES(BOOT)) dut (
    .clk(clk), .reset(reset), .stall_if(stall_if),
    .trap_req(trap_req), .trap_vector(trap_vector),
    .ex_redirect_req(ex_redirect_req), .ex_target(ex_target),
    .id_jump_req(id_jump_req), .id_target(id_target),
    .pc_enable(pc_enable), .pc_load_enable(pc_load_enable), .pc_load(pc_load),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .redirect_taken(redirect_taken), .redirect_src(redirect_src),
    .misaligned_target(misaligned_target)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Evaluates the current inputs against the model, then advances the model by one clock.
  task automatic model_cycle();
    int          w_prio, fl_prio, e_src;
    logic [31:0] w_addr, e_load;
    bit          w_mis, e_en, e_ld, e_tk, e_mis, take_new;
    w_prio = 0; w_addr = 32'd0; w_mis = 0; fl_prio = 0; e_src = 0;
    e_load = 32'd0; e_en = 0; e_ld = 0; e_tk = 0; e_mis = 0;
    if (id_jump_req)     begin w_prio = 1; w_addr = id_target;   end
    if (ex_redirect_req) begin w_prio = 2; w_addr = ex_target;   end
    if (trap_req)        begin w_prio = 3; w_addr = trap_vector; end
    if ((w_prio == 1 || w_prio == 2) && (w_addr % 4 != 0)) begin
      w_prio = 3; w_addr = trap_vector; w_mis = 1;
    end
    if (boot_left > 0) begin
      boot_left--;
    end else if (!pend) begin
      if (w_prio > 0) begin
        fl_prio = w_prio; e_src = w_prio; e_mis = w_mis;
        if (stall_if) begin
          pend = 1; pend_prio = w_prio; pend_addr = w_addr;
        end else begin
          e_en = 1; e_ld = 1; e_load = w_addr; e_tk = 1;
        end
      end else begin
        e_en = !stall_if;
      end
    end else begin
      take_new = (w_prio > 0) && (w_prio >= pend_prio);
      if (take_new) begin
        fl_prio = w_prio; e_mis = w_mis; pend_prio = w_prio; pend_addr = w_addr;
      end
      e_src = pend_prio;
      if (!stall_if) begin
        e_en = 1; e_ld = 1; e_load = pend_addr; e_tk = 1; pend = 0;
      end
    end
    check_val("pc_enable",      32'(pc_enable),         32'(e_en));
    check_val("pc_load_enable", 32'(pc_load_enable),    32'(e_ld));
    check_val("pc_load",        pc_load,                e_load);
    check_val("flush_if_id",    32'(flush_if_id),       32'(fl_prio >= 1));
    check_val("flush_id_ex",    32'(flush_id_ex),       32'(fl_prio >= 2));
    check_val("flush_ex_mem",   32'(flush_ex_mem),      32'(fl_prio == 3));
    check_val("redirect_taken", 32'(redirect_taken),    32'(e_tk));
    check_val("redirect_src",   32'(redirect_src),      32'(e_src));
    check_val("misaligned",     32'(misaligned_target), 32'(e_mis));
  endtask

  task automatic step(input logic st, input logic tr, input logic exr, input logic idr,
                      input logic [31:0] tv, input logic [31:0] ext, input logic [31:0] idt);
    @(negedge clk);
    stall_if = st; trap_req = tr; ex_redirect_req = exr; id_jump_req = idr;
    trap_vector = tv; ex_target = ext; id_target = idt;
    #1;
    model_cycle();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("rst_pc_load", pc_load, 32'd0);
    check_val("rst_ctrl", 32'({pc_enable, pc_load_enable, flush_if_id, flush_id_ex, flush_ex_mem,
                               redirect_taken, redirect_src, misaligned_target}), 32'd0);
    boot_left = BOOT; pend = 0; pend_prio = 0; pend_addr = 32'd0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  localparam logic [31:0] TV = 32'h8000_0040;

  initial begin
    logic [31:0] r_tv, r_ex, r_id;
    boot_left = BOOT; pend = 0; pend_prio = 0; pend_addr = 32'd0;
    apply_reset();

    // EX request during boot must be ignored.
    step(0, 0, 1, 0, TV, 32'h8000_0100, 32'd0);
    check_val("boot0_en", 32'(pc_enable), 32'd0);
    step(0, 0, 1, 0, TV, 32'h8000_0100, 32'd0);
    check_val("boot1_en", 32'(pc_enable), 32'd0);
    step(0, 0, 0, 0, TV, 32'd0, 32'd0);
    check_val("run_en", 32'(pc_enable), 32'd1);
    check_val("run_ld", 32'(pc_load_enable), 32'd0);

    step(0, 0, 1, 0, TV, 32'h8000_0100, 32'd0);
    check_val("ex_load", pc_load, 32'h8000_0100);
    check_val("ex_flush", 32'({flush_if_id, flush_id_ex, flush_ex_mem}), 32'b110);
    check_val("ex_src", 32'(redirect_src), 32'd2);

    step(0, 1, 1, 1, TV, 32'h8000_0100, 32'h8000_0200);
    check_val("all_load", pc_load, TV);
    check_val("all_flush", 32'({flush_if_id, flush_id_ex, flush_ex_mem}), 32'b111);
    check_val("all_src", 32'(redirect_src), 32'd3);

    step(1, 0, 0, 1, TV, 32'd0, 32'h8000_0300);
    check_val("idst0_flush", 32'(flush_if_id), 32'd1);
    step(1, 0, 0, 0, TV, 32'd0, 32'd0);
    check_val("idst1_flush", 32'(flush_if_id), 32'd0);
    step(1, 0, 0, 0, TV, 32'd0, 32'd0);
    check_val("idst2_en", 32'(pc_enable), 32'd0);
    step(0, 0, 0, 0, TV, 32'd0, 32'd0);
    check_val("idrel_load", pc_load, 32'h8000_0300);
    check_val("idrel_taken", 32'(redirect_taken), 32'd1);
    step(0, 0, 0, 0, TV, 32'd0, 32'd0);
    check_val("idrel_once", 32'(redirect_taken), 32'd0);

    step(1, 0, 0, 1, TV, 32'd0, 32'h8000_0400);
    step(1, 1, 0, 0, TV, 32'd0, 32'd0);
    check_val("trapov_flush", 32'({flush_if_id, flush_id_ex, flush_ex_mem}), 32'b111);
    step(0, 0, 0, 0, TV, 32'd0, 32'd0);
    check_val("trapov_load", pc_load, TV);
    check_val("trapov_src", 32'(redirect_src), 32'd3);

    step(0, 0, 1, 0, TV, 32'h8000_0102, 32'd0);
    check_val("mis_load", pc_load, TV);
    check_val("mis_flag", 32'(misaligned_target), 32'd1);
    check_val("mis_src", 32'(redirect_src), 32'd3);

    // Reset in the middle of HOLD drops the pending redirect.
    step(1, 0, 0, 1, TV, 32'd0, 32'h8000_0500);
    apply_reset();
    step(0, 0, 0, 0, TV, 32'd0, 32'd0);
    step(0, 0, 0, 0, TV, 32'd0, 32'd0);
    step(0, 0, 0, 0, TV, 32'd0, 32'd0);
    check_val("postrst_ld", 32'(pc_load_enable), 32'd0);
    check_val("postrst_en", 32'(pc_enable), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end
      r_tv = $urandom;
      r_tv[1:0] = 2'b00;
      r_ex = $urandom;
      if ($urandom_range(0, 3) != 0) r_ex[1:0] = 2'b00;
      r_id = $urandom;
      if ($urandom_range(0, 3) != 0) r_id[1:0] = 2'b00;
      step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 25, r_tv, r_ex, r_id);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
